uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; presets to the idle level.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, start bit validated at its centre, data sampled at bit centres.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_reg;
  uart_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;
  logic                 sample_data;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rx_prev_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      rx_prev_reg  <= rx_s;
    end
  end

  assign sample_data = (state_reg == DATA) && (cnt_reg == CNT_LAST);

  // Each shift-register bit loads only when its index is the one being sampled.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign shift_next[gi] = (sample_data && (idx_reg == IDX_W'(gi))) ? rx_s : shift_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_W'(1);
    idx_next      = idx_reg;
    data_out_next = data_out_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // Edge rather than level, so a line stuck low cannot start a new frame.
        if (rx_prev_reg && !rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) begin
            valid_next    = 1'b1;
            data_out_next = shift_reg;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    data_out   = data_out_reg;
    data_valid = valid_reg;
    frame_err  = err_reg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected frames queued at stimulus time, matched against observed pulses.
module tb_uart_rx;

  localparam int CPB = 16;
  // Line low after cycle s -> rx_s low at T=s+2 -> stop sample T+152 -> pulse T+153.
  localparam int PULSE_LAT = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } event_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_overlap = 0;
  event_t exp_q[$];
  event_t obs_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid && frame_err) n_overlap++;
    if (data_valid || frame_err) begin
      obs_q.push_back('{is_err: frame_err, data: data_out, cyc: cyc});
      $display("obs  cyc=%0d %s data_out=%02h", cyc, frame_err ? "frame_err" : "data_valid", data_out);
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_events(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got data_out=%02h valid=%b err=%b busy=%b, want 00 0 0 0",
               data_out, data_valid, frame_err, busy);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("txn  reset released cyc=%0d", cyc);
  endtask

  task automatic test_single_frame;
    int s;
    event_t e, o;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_err: 1'b0, data: 8'hA5, cyc: cyc + PULSE_LAT});
    send_frame(8'hA5, 1'b1, s);
    $display("txn  sent A5 start_cyc=%0d", s);
    wait_events(1, 40);
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d events, want 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks += 3;
      if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL single_kind: got err=%b want %b", o.is_err, e.is_err); end
      if (o.data !== e.data) begin n_fail++; $display("FAIL single_data: got %02h want %02h", o.data, e.data); end
      if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL single_cycle: got %0d want %0d", o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_glitch;
    int s;
    @(posedge clk);
    #1;
    s  = cyc;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    // Start check at T+8 reads high; IDLE is visible from T+9.
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0 at cyc %0d", busy, cyc); end
    repeat (30) @(posedge clk);
    #1;
    n_checks += 2;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d events want 0", obs_q.size()); end
    if (data_out !== 8'hA5) begin n_fail++; $display("FAIL glitch_data: got %02h want A5", data_out); end
    $display("txn  glitch start_cyc=%0d", s);
    obs_q.delete();
  endtask

  task automatic test_frame_error;
    int s;
    event_t e, o;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_err: 1'b1, data: 8'hA5, cyc: cyc + PULSE_LAT});
    send_frame(8'h3C, 1'b0, s);
    rx = 1'b1;
    $display("txn  sent 3C bad stop start_cyc=%0d", s);
    wait_events(1, 40);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d events want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks += 3;
      if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL ferr_kind: got err=%b want %b", o.is_err, e.is_err); end
      if (o.data !== e.data) begin n_fail++; $display("FAIL ferr_data_kept: got %02h want %02h", o.data, e.data); end
      if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL ferr_cycle: got %0d want %0d", o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int s0, s1;
    event_t e, o;
    @(posedge clk);
    #1;
    exp_q.push_back('{is_err: 1'b0, data: 8'h00, cyc: cyc + PULSE_LAT});
    exp_q.push_back('{is_err: 1'b0, data: 8'hFF, cyc: cyc + 10 * CPB + PULSE_LAT});
    send_frame(8'h00, 1'b1, s0);
    send_frame(8'hFF, 1'b1, s1);
    $display("txn  sent 00,FF back-to-back start_cyc=%0d,%0d", s0, s1);
    wait_events(2, 40);
    n_checks++;
    if (obs_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d events want 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks += 3;
      if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL b2b_kind: got err=%b want %b", o.is_err, e.is_err); end
      if (o.data !== e.data) begin n_fail++; $display("FAIL b2b_data: got %02h want %02h", o.data, e.data); end
      if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL b2b_cycle: got %0d want %0d", o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int s;
    logic [7:0] b;
    event_t e, o;
    b = 8'h5A;
    @(posedge clk);
    #1;
    s = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = b[3];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data_cleared: got %02h want 00", data_out); end
    if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pulses: got valid=%b err=%b want 0 0", data_valid, frame_err);
    end
    repeat (3 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_events: got %0d want 0", obs_q.size()); end
    $display("txn  aborted 5A by reset start_cyc=%0d", s);
    obs_q.delete();
    exp_q.push_back('{is_err: 1'b0, data: 8'hC3, cyc: cyc + PULSE_LAT});
    send_frame(8'hC3, 1'b1, s);
    $display("txn  sent C3 start_cyc=%0d", s);
    wait_events(1, 40);
    n_checks++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL c3_count: got %0d events want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks += 3;
      if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL c3_kind: got err=%b want %b", o.is_err, e.is_err); end
      if (o.data !== e.data) begin n_fail++; $display("FAIL c3_data: got %02h want %02h", o.data, e.data); end
      if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL c3_cycle: got %0d want %0d", o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_break;
    int s;
    event_t e, o;
    @(posedge clk);
    #1;
    s = cyc;
    exp_q.push_back('{is_err: 1'b1, data: 8'hC3, cyc: s + PULSE_LAT});
    rx = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_no_retrigger: busy=%b want 0 while line low", busy); end
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("txn  break 30 bit times start_cyc=%0d", s);
    n_checks += 2;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL break_count: got %0d events want 1", obs_q.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_idle_after: busy=%b want 0", busy); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks += 3;
      if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL break_kind: got err=%b want %b", o.is_err, e.is_err); end
      if (o.data !== e.data) begin n_fail++; $display("FAIL break_data: got %02h want %02h", o.data, e.data); end
      if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL break_cycle: got %0d want %0d", o.cyc, e.cyc); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_exclusive_pulses;
    n_checks++;
    if (n_overlap !== 0) begin
      n_fail++;
      $display("FAIL pulse_exclusive: %0d cycles with both pulses, want 0", n_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_exclusive_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
